fifo: RTL and testbench
=======================

Name: fifo

Overview:
Synchronous single-clock FIFO buffer of 10-bit words, 16 entries deep, with push/pop strobes and registered read data. It exposes the occupancy count and empty/full flags so upstream and downstream logic can throttle. General-purpose buffering block between a producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 10, width of inp_data/out_data and of each storage word
DEPTH, 16, number of storage entries (power of two)
ADDR_WIDTH, 4, log2(DEPTH), width of the read/write pointers
COUNT_WIDTH, 5, ADDR_WIDTH+1, width of cur_size (holds 0..DEPTH)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  write strobe; inp_data written on the rising edge where push=1 and write is accepted
pop  input  1  read strobe; head word moved to out_data on the rising edge where pop=1 and read is accepted
inp_data  input  DATA_WIDTH  write data
empty  output  1  high when cur_size==0
full  output  1  high when cur_size==DEPTH
cur_size  output  COUNT_WIDTH  number of stored words, 0..DEPTH
out_data  output  DATA_WIDTH  registered read data; last popped word

Behaviour:
- Reset (reset=1 at rising clk edge, overrides push/pop): wr_ptr=0, rd_ptr=0, cur_size=0, out_data=0; hence empty=1, full=0. Storage array is not cleared. Reset mid-operation discards all contents.
- empty and full are combinational decodes of the registered count; no other logic feeds them.
- Write accept: wr_en = push & (~full | pop_ok), where pop_ok = pop & ~empty. On wr_en: mem[wr_ptr] <= inp_data, wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0 by natural ADDR_WIDTH overflow).
- Read accept: rd_en = pop & ~empty. On rd_en: out_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1 (wraps). Latency: word available on out_data immediately after the accepting edge (one-cycle registered read).
- out_data holds its value on every edge without rd_en, including pops on empty.
- Push when full with no pop: ignored; contents, pointers, count unchanged.
- Pop when empty: ignored; out_data holds, count stays 0.
- Simultaneous push and pop:
  - empty: only the push is accepted, count 0->1, out_data unchanged (no bypass).
  - full: both accepted, the head goes to out_data, the new word is written into the freed slot, and count stays DEPTH.
  - otherwise: both accepted, count unchanged.
- Count update: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- Ordering is strict FIFO across pointer wrap-around.
- Inputs are sampled only at the rising edge. Strobes are level-sensitive per edge: push or pop held high for N edges performs N operations.

Test Plan:
- Reset then 4 idle cycles -> empty=1, full=0, cur_size=0, out_data=0.
- Push 1,2,3,4 on separate edges -> cur_size 1,2,3,4 after each, empty=0 after first push, full=0.
- Then pop 6 times -> out_data 1,2,3,4 after the first four pops with cur_size 3,2,1,0. Pops 5–6 are ignored: out_data stays 4, cur_size=0, empty=1.
- Push 16 words 0x001..0x010 -> full=1, cur_size=16. A 17th push (0x3FF) is ignored. Pop all 16 -> out_data sequence 0x001..0x010, with no 0x3FF.
- Wrap-around: push 12, pop 12, push 10, pop 10 -> data returned in order, cur_size back to 0.
- At full, push+pop on the same edge -> cur_size stays 16 and the head word is on out_data. At empty, push+pop -> cur_size=1 and out_data unchanged. Assert reset while 5 words are stored -> next cycle cur_size=0, empty=1, out_data=0.

Source files
------------

// File: rtl/fifo_if.sv
// Handshake bundle between a producer/consumer and the fifo: the strobes and write data
// go toward the fifo; the flags, count and read data come back.
interface fifo_if #(
  parameter int DATA_WIDTH  = 10,
  parameter int COUNT_WIDTH = 5
);
  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  inp_data;
  logic                   empty;
  logic                   full;
  logic [COUNT_WIDTH-1:0] cur_size;
  logic [DATA_WIDTH-1:0]  out_data;

  modport master (
    output push, pop, inp_data,
    input  empty, full, cur_size, out_data
  );

  modport slave (
    input  push, pop, inp_data,
    output empty, full, cur_size, out_data
  );
endinterface

// File: rtl/fifo.sv
// Single-clock 16 x 10-bit FIFO with a registered read port, an occupancy count, and
// empty/full flags decoded from that count.
module fifo #(
  parameter int DATA_WIDTH  = 10,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int COUNT_WIDTH = 5
) (
  input logic   clk,
  input logic   reset,
  fifo_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   empty;
  logic                   full;
  logic                   rd_en;
  logic                   wr_en;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // When full, a same-edge pop frees the head slot, so the push may still be taken.
  assign rd_en = bus.pop & ~empty;
  assign wr_en = bus.push & (~full | rd_en);

  // Storage is deliberately not cleared on reset; resetting the pointers is enough.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= bus.inp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.cur_size = count;
  assign bus.out_data = rd_data;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a directed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model.
module tb_fifo;
  localparam int DW    = 10;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_out;

  fifo_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(5)) f ();

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4), .COUNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (f.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] data;
    int            exp_size;
    logic [DW-1:0] exp_out;
    logic          exp_empty;
    logic          exp_full;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: pop the head first (only if non-empty), then append if room.
  task automatic model_step(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
    bit pop_ok;
    bit wr_ok;
    if (r) begin
      model_q.delete();
      model_out = '0;
    end else begin
      pop_ok = q && (model_q.size() > 0);
      wr_ok  = p && ((model_q.size() < DEPTH) || pop_ok);
      if (pop_ok) model_out = model_q.pop_front();
      if (wr_ok)  model_q.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cur_size"}, int'(f.cur_size), model_q.size());
    chk({tag, ".empty"},    int'(f.empty),    int'(model_q.size() == 0));
    chk({tag, ".full"},     int'(f.full),     int'(model_q.size() == DEPTH));
    chk({tag, ".out_data"}, int'(f.out_data), int'(model_out));
  endtask

  task automatic step(input logic r, input logic p, input logic q, input logic [DW-1:0] d,
                      input string tag);
    @(negedge clk);
    reset      = r;
    f.push     = p;
    f.pop      = q;
    f.inp_data = d;
    @(posedge clk);
    model_step(r, p, q, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    f.push     = 1'b0;
    f.pop      = 1'b0;
    f.inp_data = '0;
    model_out  = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 10'h000, 0, 10'h000, 1'b1, 1'b0};
    for (int i = 1; i <= 4; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 10'h000, 0, 10'h000, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++)
      vecs[5+i] = '{1'b0, 1'b1, 1'b0, DW'(i+1), i+1, 10'h000, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++)
      vecs[9+i] = '{1'b0, 1'b0, 1'b1, 10'h000, 3-i, DW'(i+1), (i == 3), 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 10'h000, 0, 10'h004, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 10'h000, 0, 10'h004, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].data, "vec");
      chk("vec.tbl_size",  int'(f.cur_size), vecs[i].exp_size);
      chk("vec.tbl_out",   int'(f.out_data), int'(vecs[i].exp_out));
      chk("vec.tbl_empty", int'(f.empty),    int'(vecs[i].exp_empty));
      chk("vec.tbl_full",  int'(f.full),     int'(vecs[i].exp_full));
    end

    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, DW'(i), "fill");
    chk("fill.full_flag", int'(f.full), 1);
    step(1'b0, 1'b1, 1'b0, 10'h3FF, "overfill");
    chk("overfill.size", int'(f.cur_size), 16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1, '0, "drain");
      chk("drain.seq", int'(f.out_data), i);
    end

    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, DW'(10'h100 + i), "wrap_a");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, '0, "wrap_a_pop");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, DW'(10'h200 + i), "wrap_b");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, '0, "wrap_b_pop");
      chk("wrap_b.seq", int'(f.out_data), 10'h200 + i);
    end
    chk("wrap.empty_size", int'(f.cur_size), 0);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, DW'(10'h050 + i), "full_pp_fill");
    step(1'b0, 1'b1, 1'b1, 10'h2AA, "full_pp");
    chk("full_pp.size", int'(f.cur_size), 16);
    chk("full_pp.head", int'(f.out_data), 10'h050);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, '0, "full_pp_drain");
    chk("full_pp.last", int'(f.out_data), 10'h2AA);

    step(1'b0, 1'b1, 1'b1, 10'h155, "empty_pp");
    chk("empty_pp.size", int'(f.cur_size), 1);
    chk("empty_pp.out",  int'(f.out_data), 10'h2AA);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, DW'(10'h0A0 + i), "pre_rst");
    chk("pre_rst.size", int'(f.cur_size), 5);
    step(1'b1, 1'b1, 1'b1, 10'h3C3, "mid_rst");
    chk("mid_rst.size", int'(f.cur_size), 0);
    chk("mid_rst.out",  int'(f.out_data), 0);
    step(1'b0, 1'b0, 1'b1, '0, "post_rst_pop");

    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      step(r, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           DW'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
